// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: sole owner of the single-port synchronous instruction RAM.
// Shares the RAM between the core fetch unit (read-only) and the boot loader (write-only).
// The core is held in BOOT until the loader signals completion. In RUN, fetch has priority,
// and a starvation counter bounds how long the loader can be kept waiting.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_req/fetch_addr       core read request (byte address)
//   fetch_gnt                  comb: read accepted this cycle
//   fetch_rvalid/_rdata/_err   response, one cycle after the grant
//   ld_req/ld_addr/ld_wdata    loader write request (word index)
//   ld_gnt                     comb: write accepted this cycle
//   ld_done                    loader finished; leave BOOT
//   booting                    registered: 1 while in BOOT
//   mem_en/_we/_addr/_wdata    RAM request (comb)
//   mem_rdata                  RAM read data, one cycle after a read
module imem_access_arbiter #(
  parameter int unsigned AW       = 6,
  parameter int unsigned MAX_WAIT = 4,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013,
  parameter bit          BOOT_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  input  logic          ld_done,
  output logic          booting,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rvalid_q, err_q;
  logic [31:0]   rdata_q;
  logic          fetch_legal;
  logic          starved;

  // Word-aligned and inside the 2**AW-word array.
  assign fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:AW+2] == '0);
  assign starved     = (wait_cnt_q == WW'(MAX_WAIT));

  always_comb begin
    state_d   = state_q;
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    unique case (state_q)
      StBoot: begin
        ld_gnt = ld_req;
        if (ld_done) state_d = StRun;
      end
      StRun: begin
        fetch_gnt = fetch_req && !(ld_req && starved);
        ld_gnt    = ld_req && !fetch_gnt;
      end
      default: state_d = StBoot;
    endcase
  end

  // Counts consecutive cycles the loader asked and lost; saturates at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (ld_req && !ld_gnt) begin
      wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (fetch_gnt && fetch_legal) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[AW+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT_EN ? StBoot : StRun;
      wait_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= fetch_gnt;
      err_q      <= fetch_gnt && !fetch_legal;
      // Remember the last delivered word so rdata holds between responses.
      if (rvalid_q) rdata_q <= fetch_rdata;
    end
  end

  // RAM data arrives the cycle after the read, so the live response bypasses rdata_q.
  assign fetch_rdata  = rvalid_q ? (err_q ? NOP_INSN : mem_rdata) : rdata_q;
  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = err_q;
  assign booting      = (state_q == StBoot);

endmodule
